// File: rtl/spi_ram_master_pkg.sv
// rtl/spi_ram_master_pkg.sv - shared constants, opcodes and FSM state type for spi_ram_master
// No ports: imported by the interface, the shifter and the top level.
package spi_ram_master_pkg;

   localparam int CMD_W  = 10;
   localparam int DATA_W = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GUARD,
      ST_SHIFT,
      ST_TURN,
      ST_CAPTURE,
      ST_GAP
   } state_e;

   // Only rd-data frames carry a reply byte from the slave.
   function automatic logic is_read_data(input logic [1:0] op);
      return op == OP_RD_DATA;
   endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// rtl/spi_ram_master_if.sv - host handshake and SPI pin bundle for spi_ram_master
// cmd_valid/cmd_ready/cmd_word : host command handshake (10-bit word)
// rd_valid/rd_data             : one-cycle reply pulse and captured byte
// busy                         : master is not idle
// MISO/MOSI/SS_n               : serial pins towards the SPI-RAM slave
// modport master : view used by spi_ram_master; modport slave : host/pin side
interface spi_ram_master_if;
   import spi_ram_master_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CMD_W-1:0]  cmd_word;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              MISO;
   logic              MOSI;
   logic              SS_n;

   modport master (
      input  cmd_valid, cmd_word, MISO,
      output cmd_ready, rd_valid, rd_data, busy, MOSI, SS_n
   );

   modport slave (
      output cmd_valid, cmd_word, MISO,
      input  cmd_ready, rd_valid, rd_data, busy, MOSI, SS_n
   );

endinterface

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - 10-bit parallel-load MSB-out shifter with 8-bit serial capture
// clk, rst   : clock, asynchronous active-high reset
// load       : load load_word into the outgoing shift register
// shift_en   : shift the outgoing register left by one
// msb        : current MSB of the outgoing register
// miso       : serial input bit
// cap_en     : shift miso into the capture register
// cap_done   : last capture bit; commit the assembled byte to rd_data
// rd_data    : most recently completed byte, held until the next commit
module spi_master_shifter
   import spi_ram_master_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [CMD_W-1:0]  load_word,
   input  logic              shift_en,
   output logic              msb,
   input  logic              miso,
   input  logic              cap_en,
   input  logic              cap_done,
   output logic [DATA_W-1:0] rd_data
);

   logic [CMD_W-1:0]  sreg_q, sreg_d;
   // Only seven bits are stored: the eighth arrives on miso in the same
   // cycle that the byte is committed.
   logic [DATA_W-2:0] cap_q, cap_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   always_comb begin
      sreg_d    = sreg_q;
      cap_d     = cap_q;
      rd_data_d = rd_data_q;
      if (load) begin
         sreg_d = load_word;
      end else if (shift_en) begin
         sreg_d = {sreg_q[CMD_W-2:0], 1'b0};
      end
      if (cap_en) begin
         cap_d = {cap_q[DATA_W-3:0], miso};
      end
      if (cap_done) begin
         rd_data_d = {cap_q, miso};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q    <= '0;
         cap_q     <= '0;
         rd_data_q <= '0;
      end else begin
         sreg_q    <= sreg_d;
         cap_q     <= cap_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign msb     = sreg_q[CMD_W-1];
   assign rd_data = rd_data_q;

endmodule

// File: rtl/spi_ram_master.sv
// rtl/spi_ram_master.sv - SPI initiator serialising 10-bit RAM commands and capturing read replies
// clk        : system and bit clock, rising edge
// rst        : asynchronous active-high reset
// bus        : spi_ram_master_if.master (host handshake, reply, busy, MISO/MOSI/SS_n)
// TURN_CYCLES: idle cycles between last command bit and first MISO sample (0..15)
// GAP_CYCLES : SS_n-high cycles between frames (1..15)
module spi_ram_master
   import spi_ram_master_pkg::*;
#(
   parameter int TURN_CYCLES = 2,
   parameter int GAP_CYCLES  = 1
) (
   input  logic clk,
   input  logic rst,
   spi_ram_master_if.master bus
);

   // Counters hold "cycles remaining minus one" for the current state.
   localparam logic [3:0] SHIFT_LOAD = 4'(CMD_W - 1);
   localparam logic [3:0] CAP_LOAD   = 4'(DATA_W - 1);
   localparam logic [3:0] TURN_LOAD  = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
   localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rd_op_q, rd_op_d;
   logic       mosi_q, mosi_d;
   logic       ss_n_q, ss_n_d;
   logic       rd_valid_q, rd_valid_d;

   logic       accept;
   logic       load;
   logic       shift_en;
   logic       cap_en;
   logic       cap_done;
   logic       sreg_msb;

   assign accept = bus.cmd_valid && bus.cmd_ready;

   spi_master_shifter u_shifter (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_word (bus.cmd_word),
      .shift_en  (shift_en),
      .msb       (sreg_msb),
      .miso      (bus.MISO),
      .cap_en    (cap_en),
      .cap_done  (cap_done),
      .rd_data   (bus.rd_data)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rd_op_d  = rd_op_q;
      load     = 1'b0;
      cap_en   = 1'b0;
      cap_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               load    = 1'b1;
               rd_op_d = is_read_data(bus.cmd_word[CMD_W-1 -: 2]);
               state_d = ST_GUARD;
            end
         end
         ST_GUARD: begin
            state_d = ST_SHIFT;
            cnt_d   = SHIFT_LOAD;
         end
         ST_SHIFT: begin
            if (cnt_q == 4'd0) begin
               if (!rd_op_q) begin
                  state_d = ST_GAP;
                  cnt_d   = GAP_LOAD;
               end else if (TURN_CYCLES == 0) begin
                  state_d = ST_CAPTURE;
                  cnt_d   = CAP_LOAD;
               end else begin
                  state_d = ST_TURN;
                  cnt_d   = TURN_LOAD;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_TURN: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_CAPTURE;
               cnt_d   = CAP_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_CAPTURE: begin
            cap_en = 1'b1;
            if (cnt_q == 4'd0) begin
               cap_done = 1'b1;
               state_d  = ST_GAP;
               cnt_d    = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Pins are registered, so they are computed from the state being
      // entered. GUARD shows the opcode MSB straight from the input word
      // because the shift register is only being loaded on that edge;
      // entering or staying in SHIFT presents the MSB while shifting it out.
      shift_en = (state_d == ST_SHIFT);
      if (state_d == ST_GUARD) begin
         mosi_d = bus.cmd_word[CMD_W-1];
      end else if (state_d == ST_SHIFT) begin
         mosi_d = sreg_msb;
      end else begin
         mosi_d = 1'b0;
      end
      ss_n_d     = !(state_d inside {ST_GUARD, ST_SHIFT, ST_TURN, ST_CAPTURE});
      rd_valid_d = cap_done;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rd_op_q    <= 1'b0;
         mosi_q     <= 1'b0;
         ss_n_q     <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_op_q    <= rd_op_d;
         mosi_q     <= mosi_d;
         ss_n_q     <= ss_n_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Gated by rst so no command can be offered while reset is held.
   assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.MOSI      = mosi_q;
   assign bus.SS_n      = ss_n_q;
   assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// tb/tb_spi_ram_master.sv - self-checking bench for spi_ram_master
module tb_spi_ram_master;
   import spi_ram_master_pkg::*;

   localparam int GAP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [9:0] cmd_word = '0;
   logic       miso = 1'b0;
   logic       sel = 1'b0;

   int checks = 0;
   int errors = 0;
   int acc0 = 0;

   always #5 clk = ~clk;

   spi_ram_master_if if0 ();
   spi_ram_master_if if1 ();

   assign if0.cmd_valid = cmd_valid & ~sel;
   assign if1.cmd_valid = cmd_valid & sel;
   assign if0.cmd_word  = cmd_word;
   assign if1.cmd_word  = cmd_word;
   assign if0.MISO      = miso;
   assign if1.MISO      = miso;

   spi_ram_master #(.TURN_CYCLES(2), .GAP_CYCLES(GAP)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.master)
   );

   spi_ram_master #(.TURN_CYCLES(0), .GAP_CYCLES(GAP)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.master)
   );

   logic       o_ready, o_ss, o_mosi, o_rdv, o_busy;
   logic [7:0] o_rd;
   assign o_ready = sel ? if1.cmd_ready : if0.cmd_ready;
   assign o_ss    = sel ? if1.SS_n      : if0.SS_n;
   assign o_mosi  = sel ? if1.MOSI      : if0.MOSI;
   assign o_rdv   = sel ? if1.rd_valid  : if0.rd_valid;
   assign o_busy  = sel ? if1.busy      : if0.busy;
   assign o_rd    = sel ? if1.rd_data   : if0.rd_data;

   always @(posedge clk) begin
      if (!rst && if0.cmd_valid && if0.cmd_ready) acc0 <= acc0 + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected per-cycle pin traces, bit k = k-th cycle after the accepting edge.
   function automatic void model(input logic [9:0] w, input int turn,
                                 output logic [63:0] ss, output logic [63:0] mosi,
                                 output logic [63:0] rdv, output logic [63:0] busy,
                                 output logic [63:0] rdy, output int len);
      int  flen;
      logic rd;
      rd   = (w[9:8] == 2'b11);
      flen = rd ? 11 + turn + 8 : 11;
      len  = flen + GAP + 1;
      ss = '0; mosi = '0; rdv = '0; busy = '0; rdy = '0;
      for (int k = 1; k <= len; k++) begin
         ss[k]   = (k > flen);
         if (k == 1)       mosi[k] = w[9];
         else if (k <= 11) mosi[k] = w[11 - k];
         rdv[k]  = rd && (k == flen + 1);
         busy[k] = (k <= flen + GAP);
         rdy[k]  = (k == len);
      end
   endfunction

   // Call at a negedge; returns at the negedge of the IDLE cycle after the frame.
   task automatic send(input logic [9:0] w, input logic [7:0] mb, input logic hold,
                       input logic [7:0] exp_rd, input string tag);
      int turn, len, n, cs;
      logic rd;
      logic [63:0] e_ss, e_mosi, e_rdv, e_busy, e_rdy;
      logic [63:0] a_ss, a_mosi, a_rdv, a_busy, a_rdy;
      turn = sel ? 0 : 2;
      rd   = (w[9:8] == 2'b11);
      cs   = 12 + turn;
      cmd_word  = w;
      cmd_valid = 1'b1;
      n = 0;
      while (!o_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " accept"}, 64'(o_ready), 64'd1);
      if (!o_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      model(w, turn, e_ss, e_mosi, e_rdv, e_busy, e_rdy, len);
      a_ss = '0; a_mosi = '0; a_rdv = '0; a_busy = '0; a_rdy = '0;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         if (k == 1) begin
            if (!hold) cmd_valid = 1'b0;
            cmd_word = 10'($urandom);
         end
         a_ss[k]   = o_ss;
         a_mosi[k] = o_mosi;
         a_rdv[k]  = o_rdv;
         a_busy[k] = o_busy;
         a_rdy[k]  = o_ready;
         if (rd && k >= cs && k < cs + 8) miso = mb[7 - (k - cs)];
         else                             miso = 1'($urandom);
      end
      chk({tag, " ss_n"},     a_ss,   e_ss);
      chk({tag, " mosi"},     a_mosi, e_mosi);
      chk({tag, " rd_valid"}, a_rdv,  e_rdv);
      chk({tag, " busy"},     a_busy, e_busy);
      chk({tag, " ready"},    a_rdy,  e_rdy);
      chk({tag, " rd_data"},  64'(o_rd), 64'(exp_rd));
   endtask

   typedef struct {
      logic [9:0] w;
      logic [7:0] mb;
      logic       s;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [7:0] last0;
      logic [9:0] rw;
      logic [7:0] rb;
      int base, rdv_seen;

      tbl[0] = '{10'h0A5, 8'h00, 1'b0, 8'h00};
      tbl[1] = '{10'h13C, 8'hFF, 1'b0, 8'h00};
      tbl[2] = '{10'h300, 8'hC3, 1'b0, 8'hC3};
      tbl[3] = '{10'h211, 8'h3C, 1'b0, 8'hC3};
      tbl[4] = '{10'h3FF, 8'h81, 1'b0, 8'h81};
      tbl[5] = '{10'h300, 8'h5A, 1'b1, 8'h5A};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst cmd_ready", 64'(if0.cmd_ready), 64'd0);
      chk("rst ss_n",      64'(if0.SS_n),      64'd1);
      chk("rst mosi",      64'(if0.MOSI),      64'd0);
      chk("rst rd_valid",  64'(if0.rd_valid),  64'd0);
      chk("rst rd_data",   64'(if0.rd_data),   64'd0);
      chk("rst busy",      64'(if0.busy),      64'd0);
      rst = 1'b0;
      #1;
      chk("rel cmd_ready", 64'(if0.cmd_ready), 64'd1);
      @(negedge clk);

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         sel = tbl[i].s;
         send(tbl[i].w, tbl[i].mb, 1'b0, tbl[i].exp_rd, $sformatf("vec%0d", i));
      end
      sel   = 1'b0;
      last0 = 8'h81;

      // Random commands with random MISO noise outside the capture window
      for (int i = 0; i < 16; i++) begin
         rw = 10'($urandom);
         rb = 8'($urandom);
         if (rw[9:8] == 2'b11) last0 = rb;
         send(rw, rb, 1'b0, last0, $sformatf("rand%0d", i));
      end

      // Back-to-back with cmd_valid held high
      base = acc0;
      send(10'h011, 8'h00, 1'b1, last0, "b2b0");
      send(10'h122, 8'h00, 1'b1, last0, "b2b1");
      send(10'h211, 8'h00, 1'b1, last0, "b2b2");
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b accept count", 64'(acc0 - base), 64'd3);

      // Reset during the 5th SHIFT cycle of a rd-data frame
      cmd_word  = 10'h3AA;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre-rst ss_n", 64'(if0.SS_n), 64'd0);
      chk("pre-rst mosi", 64'(if0.MOSI), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid-rst ss_n", 64'(if0.SS_n), 64'd1);
      chk("mid-rst mosi", 64'(if0.MOSI), 64'd0);
      chk("mid-rst busy", 64'(if0.busy), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rdv_seen = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (if0.rd_valid) rdv_seen++;
      end
      chk("aborted rd_valid", 64'(rdv_seen), 64'd0);
      send(10'h300, 8'h96, 1'b0, 8'h96, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_ram_master.md
Name: spi_ram_master

Overview:
- SPI initiator that drives the SPI-RAM slave wrapper's serial pins (MOSI, SS_n) and samples MISO.
- Accepts 10-bit RAM command words from a host over a valid/ready handshake and serialises them MSB-first.
- For read-data commands, captures the 8-bit reply and returns it to the host.
- Runs on the system clock, which is also the serial bit clock; no separate SCLK.

Parameters:
- TURN_CYCLES, 2, idle cycles between the last command bit and the first MISO sample on read-data frames; range 0..15.
- GAP_CYCLES, 1, cycles SS_n is held high between frames; range 1..15.

Ports:
- clk  input  1  system and bit clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  host command present.
- cmd_ready  output  1  master can accept a command; high only in IDLE.
- cmd_word  input  10  [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rd_valid  output  1  one-cycle pulse; rd_data is valid.
- rd_data  output  8  byte captured from MISO; holds until the next capture.
- busy  output  1  high whenever state is not IDLE.
- MISO  input  1  serial data from the slave.
- MOSI  output  1  serial data to the slave; registered.
- SS_n  output  1  slave select, active-low; registered.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after release. MOSI=0, SS_n=1, rd_valid=0, rd_data=8'h00, busy=0.
- Reset is asynchronous. Asserting rst mid-frame forces SS_n=1 and MOSI=0 immediately. The frame is aborted, no rd_valid is produced, and the state returns to IDLE.
- States: IDLE, GUARD, SHIFT, TURN, CAPTURE, GAP.
- IDLE:
  - cmd_ready=1, SS_n=1, MOSI=0.
  - On an edge with cmd_valid&cmd_ready: latch cmd_word into the shift register, go to GUARD.
  - cmd_word is sampled only at acceptance; later changes are ignored.
- GUARD: 1 cycle. SS_n=0, MOSI=cmd_word[9], the mode-select slot read by the slave's command-check state. Go to SHIFT.
- SHIFT: 10 cycles. MOSI=word[9] down to word[0], one bit per cycle, MSB first.
  - After bit 0: opcode 11 goes to TURN, or straight to CAPTURE if TURN_CYCLES=0.
  - Any other opcode goes to GAP.
- TURN: TURN_CYCLES cycles. SS_n=0, MOSI=0.
- CAPTURE: 8 cycles. SS_n=0, MOSI=0.
  - MISO is sampled at the rising edge ending each CAPTURE cycle and shifted in MSB first.
  - At the edge ending the 8th cycle: rd_data is updated, rd_valid=1 for exactly the following cycle, go to GAP.
- GAP: GAP_CYCLES cycles. SS_n=1, MOSI=0. Then go to IDLE.
- Frame lengths with SS_n low:
  - Write or rd-addr: 11 cycles.
  - rd-data: 11+TURN_CYCLES+8 cycles.
- Back-to-back: with cmd_valid held high, the next acceptance is at the first IDLE cycle. Throughput is one command per (frame + GAP_CYCLES + 1) cycles.
- rd_valid is never asserted for opcodes 00, 01, 10.
- MISO is ignored outside CAPTURE.
- Counters are 4-bit and saturate-free: each counter is reloaded on state entry, never wrapped.

Decomposition:
- spi_ram_master_pkg contains:
  - opcode localparams OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA;
  - the state enum;
  - CMD_W=10 and DATA_W=8.
- One sub-module: spi_master_shifter, a 10-bit parallel-load, MSB-out shift register with an 8-bit serial-in capture path. The top level holds the FSM and counters.

Test Plan:
- rst deasserted; cmd_word=10'h0A5 (wr-addr) accepted at edge T:
  - SS_n low for edges T+1..T+11;
  - MOSI=0 in GUARD, then 0,0,1,0,1,0,0,1,0,1;
  - SS_n high for 1 cycle, then cmd_ready=1.
- cmd_word=10'h1_3C (wr-data 0x3C):
  - MOSI bits 0,1,0,0,1,1,1,1,0,0;
  - no rd_valid; busy high throughout the frame.
- cmd_word=10'h3_00 (rd-data) with a slave model driving MISO=8'hC3 MSB-first over the 8 CAPTURE cycles after 2 TURN cycles:
  - rd_data=8'hC3;
  - rd_valid high for exactly 1 cycle, 22 cycles after acceptance.
- cmd_valid held high with commands 10'h0_11, 10'h1_22, 10'h2_11:
  - three frames separated by exactly 1 SS_n-high cycle;
  - each command accepted once.
- rst asserted during the 5th SHIFT cycle of a rd-data frame:
  - SS_n=1 and MOSI=0 before the next clk edge;
  - no rd_valid;
  - a new command after release completes normally.
- TURN_CYCLES=0 build, rd-data with MISO=8'h5A:
  - CAPTURE starts the cycle after bit 0;
  - rd_data=8'h5A.
